cla32_pipe_addsub: RTL and testbench

//  Two-stage pipelined WIDTH-bit add/subtract unit built from the 8-bit CLA

---
 rtl/cla32_pipe_addsub.sv | 147 ++++++++++++++
 tb/tb_cla32_pipe_addsub.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cla32_pipe_addsub.sv
// Two-stage pipelined add/subtract: low half in stage 1, high half plus flags in stage 2.
// The halves are built from 8-bit carry-lookahead group slices.

module cla32_pipe_addsub_cla8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);
  logic [7:0] g, p;
  logic [8:0] c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c[0] = ci;
    for (int i = 0; i < 8; i++) c[i+1] = g[i] | (p[i] & c[i]);
  end

  assign s  = p ^ c[7:0];
  assign co = c[8];
endmodule

module cla32_pipe_addsub_cla #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  localparam int NG = W / 8;
  logic [NG:0] gc;

  assign gc[0] = ci;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    cla32_pipe_addsub_cla8 u_grp (
      .a  (a[gi*8 +: 8]),
      .b  (b[gi*8 +: 8]),
      .ci (gc[gi]),
      .s  (s[gi*8 +: 8]),
      .co (gc[gi+1])
    );
  end

  assign co = gc[NG];
endmodule

module cla32_pipe_addsub #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);
  localparam int LO_W = WIDTH / 2;
  localparam int HI_W = WIDTH - LO_W;

  logic [WIDTH-1:0] bx;
  logic [LO_W-1:0]  lo_sum;
  logic             lo_co;
  logic [HI_W-1:0]  hi_sum;
  logic             hi_co;

  logic             s1_valid, s2_valid;
  logic [LO_W-1:0]  s1_lo;
  logic             s1_c;
  logic [HI_W-1:0]  s1_ahi, s1_bhi;

  logic             s2_free, s1_adv, accept;

  // Subtraction is A + ~B + 1: the +1 enters as the low-half carry-in.
  assign bx = sub ? ~b : b;

  cla32_pipe_addsub_cla #(.W(LO_W)) u_lo (
    .a  (a[LO_W-1:0]),
    .b  (bx[LO_W-1:0]),
    .ci (sub),
    .s  (lo_sum),
    .co (lo_co)
  );

  cla32_pipe_addsub_cla #(.W(HI_W)) u_hi (
    .a  (s1_ahi),
    .b  (s1_bhi),
    .ci (s1_c),
    .s  (hi_sum),
    .co (hi_co)
  );

  assign s2_free   = !s2_valid | out_ready;
  assign s1_adv    = s1_valid & s2_free;
  assign in_ready  = !s1_valid | s1_adv;
  assign accept    = in_valid & in_ready;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      s1_c     <= 1'b0;
      s1_ahi   <= '0;
      s1_bhi   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_lo    <= lo_sum;
      s1_c     <= lo_co;
      s1_ahi   <= a[WIDTH-1:LO_W];
      s1_bhi   <= bx[WIDTH-1:LO_W];
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Overflow uses the already-inverted B, so one rule covers add and subtract.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      s2_valid <= 1'b0;
      s        <= '0;
      c_out    <= 1'b0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      s        <= {hi_sum, s1_lo};
      c_out    <= hi_co;
      ovf      <= (s1_ahi[HI_W-1] == s1_bhi[HI_W-1]) & (hi_sum[HI_W-1] != s1_ahi[HI_W-1]);
      zero     <= ({hi_sum, s1_lo} == '0);
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cla32_pipe_addsub.sv
// Bench for cla32_pipe_addsub: directed corner cases plus randomized add/sub
// traffic with random backpressure, checked against an arithmetic reference queue.

module tb_cla32_pipe_addsub;
  localparam int W = 32;

  logic         clk, clrn, in_valid, in_ready, sub, out_valid, out_ready;
  logic [W-1:0] a, b, s;
  logic         c_out, ovf, zero;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    logic         z;
    longint       acc;
  } res_t;

  res_t   q[$];
  longint cyc = 0;
  int     errors = 0, checks = 0;
  int     accepted = 0, offered = 0;
  bit     pend = 0;
  logic [W-1:0] pa, pb;
  logic         psub;

  cla32_pipe_addsub #(.WIDTH(W)) dut (
    .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .c_out(c_out), .ovf(ovf), .zero(zero)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain signed/unsigned integer arithmetic on 64-bit values.
  function automatic res_t model(logic [W-1:0] x, logic [W-1:0] y, logic sb);
    res_t   m;
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint ux = longint'({32'b0, x});
    longint uy = longint'({32'b0, y});
    longint r;
    r   = sb ? sx - sy : sx + sy;
    m.s = r[W-1:0];
    m.o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    m.c = sb ? (x >= y) : (((ux + uy) >> 32) != 0);
    m.z = (m.s == 0);
    m.acc = 0;
    return m;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clrn) q.delete();

  // Compare process: occupancy and beat age decide in_ready / out_valid.
  always @(negedge clk) begin
    #2;
    if (clrn) begin
      chk("in_ready", in_ready, (q.size() < 2) || out_ready);
      chk("out_valid", out_valid, (q.size() > 0) && (cyc - q[0].acc >= 2));
      if (out_valid && q.size() > 0) begin
        chk("result", {s, c_out, ovf, zero}, {q[0].s, q[0].c, q[0].o, q[0].z});
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        res_t r;
        r = model(a, b, sub);
        r.acc = cyc;
        q.push_back(r);
      end
    end
  end

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'hFFFFFFFF;
      1: return 32'h0000FFFF;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  // One cycle: the producer holds its beat until it is taken.
  task automatic cycle(input bit want, input bit rdy);
    @(negedge clk);
    if (!pend && want) begin
      pa = pick(); pb = pick(); psub = $urandom_range(0, 1);
      pend = 1; offered++;
    end
    in_valid  = pend;
    a = pa; b = pb; sub = psub;
    out_ready = rdy;
    #1;
    if (in_valid && in_ready) begin
      pend = 0;
      accepted++;
    end
  endtask

  task automatic load(input logic [W-1:0] x, input logic [W-1:0] y, input logic sb);
    pa = x; pb = y; psub = sb; pend = 1;
  endtask

  task automatic expect_lit(input string nm, input logic [W-1:0] es, input logic ec,
                            input logic eo, input logic ez);
    bit got = 0;
    for (int k = 0; k < 6 && !got; k++) begin
      cycle(0, 1);
      if (out_valid) begin
        got = 1;
        chk(nm, {s, c_out, ovf, zero}, {es, ec, eo, ez});
      end
    end
    if (!got) chk({nm, " timeout"}, 0, 1);
  endtask

  initial begin
    res_t r;
    int   a0, off0;
    clrn = 0; in_valid = 0; a = 0; b = 0; sub = 0; out_ready = 1;
    pa = 0; pb = 0; psub = 0;
    #2;
    chk("rst out_valid", out_valid, 0);
    chk("rst s", s, 0);
    chk("rst flags", {c_out, ovf, zero}, 3'b000);
    @(negedge clk);
    @(negedge clk);
    clrn = 1;
    #1 chk("in_ready after rst", in_ready, 1);

    // Pin the reference against hand-computed values.
    r = model(32'h0000FFFF, 32'h1, 0);
    chk("model add", {r.s, r.c, r.o, r.z}, {32'h00010000, 3'b000});
    r = model(32'h3, 32'h5, 1);
    chk("model sub", {r.s, r.c, r.o, r.z}, {32'hFFFFFFFE, 3'b000});
    r = model(32'h7FFFFFFF, 32'h1, 0);
    chk("model ovf", {r.s, r.c, r.o, r.z}, {32'h80000000, 3'b010});
    r = model(32'h80000000, 32'h1, 1);
    chk("model sub ovf", {r.s, r.c, r.o, r.z}, {32'h7FFFFFFF, 3'b110});

    // Directed corner cases through the DUT.
    load(32'h0000FFFF, 32'h1, 0); cycle(0, 1);
    expect_lit("mid carry", 32'h00010000, 0, 0, 0);
    load(32'h5, 32'h5, 1); cycle(0, 1);
    expect_lit("sub equal", 32'h0, 1, 0, 1);
    load(32'h3, 32'h5, 1); cycle(0, 1);
    expect_lit("sub borrow", 32'hFFFFFFFE, 0, 0, 0);
    load(32'h7FFFFFFF, 32'h1, 0); cycle(0, 1);
    expect_lit("add ovf", 32'h80000000, 0, 1, 0);
    load(32'hFFFFFFFF, 32'h1, 0); cycle(0, 1);
    expect_lit("add wrap", 32'h0, 1, 0, 1);

    // Back-to-back beats.
    a0 = accepted;
    repeat (8) cycle(1, 1);
    chk("b2b accepts", accepted - a0, 8);
    repeat (3) cycle(0, 1);

    // Stall: two-deep, then release in order.
    a0 = accepted; off0 = offered;
    repeat (5) cycle(1, 0);
    chk("stall accepts", accepted - a0, 2);
    chk("stall in_ready", in_ready, 0);
    for (int k = 0; k < 10; k++) cycle((offered - off0) < 4, 1);
    chk("release accepts", accepted - a0, 4);

    // Reset with both stages full.
    repeat (3) cycle(1, 0);
    @(negedge clk);
    in_valid = 0; pend = 0;
    #4 clrn = 0;
    #1 chk("async clear", out_valid, 0);
    @(negedge clk);
    clrn = 1;
    repeat (4) cycle(0, 1);
    chk("no stale", out_valid, 0);

    // Random traffic with random backpressure.
    a0 = accepted;
    for (int k = 0; k < 60000 && accepted < a0 + 10000; k++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    chk("random beats", accepted - a0 >= 10000, 1);
    for (int k = 0; k < 20 && (q.size() > 0 || pend); k++) cycle(pend, 1);
    cycle(0, 1);
    chk("drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
